// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes, mux selects.
package mips_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned COUNT_W  = 32;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

   // ALUOp: add, subtract (branch compare), decode from funct field
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // PCSource: ALU result, ALUOut register, jump target
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALUSrcB: register B, constant 4, sign-extended imm, shifted imm
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_SHIFT = 2'b11;

endpackage

// File: rtl/retire_counter.sv
// Free-running count of retired instructions; wraps modulo 2^32.
module retire_counter
   import mips_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   // Count register; holds when inc is low
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (inc)
         count <= count + COUNT_W'(1);
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with retired-instruction counter.
module multicycle_control
   import mips_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1
)(
   input  logic                clock,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                MemtoReg,
   output logic                ALUSrcA,
   output logic                RegWrite,
   output logic                RegDst,
   output logic [1:0]          PCSource,
   output logic [1:0]          ALUOp,
   output logic [1:0]          ALUSrcB,
   output logic [STATE_W-1:0]  state,
   output logic                illegal_op,
   output logic [COUNT_W-1:0]  instr_count
);

   state_t state_q;
   state_t state_d;
   logic   ready;
   logic   retire;

   assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;
   assign state = state_q;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_q <= S_FETCH;
      else
         state_q <= state_d;
   end

   // Next state and Moore-style control decode; everything is held low during reset
   always_comb begin
      state_d     = S_FETCH;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUOp       = ALUOP_ADD;
      ALUSrcB     = SRCB_REG;
      illegal_op  = 1'b0;
      retire      = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = ready;
            PCWrite = ready;
            state_d = ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_SHIFT;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EX;
               default: begin
                  state_d    = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            state_d = ready ? S_MEM_WB : S_MEM_READ;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            retire   = 1'b1;
         end
         S_MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            state_d  = ready ? S_FETCH : S_MEM_WRITE;
            retire   = ready;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
            state_d = S_R_WB;
         end
         S_R_WB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            retire      = 1'b1;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
            retire   = 1'b1;
         end
         S_ADDI_EX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         MemtoReg    = 1'b0;
         ALUSrcA     = 1'b0;
         RegWrite    = 1'b0;
         RegDst      = 1'b0;
         PCSource    = 2'b00;
         ALUOp       = 2'b00;
         ALUSrcB     = 2'b00;
         illegal_op  = 1'b0;
         retire      = 1'b0;
      end
   end

   retire_counter u_retire (
      .clock (clock),
      .reset (reset),
      .inc   (retire),
      .count (instr_count)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;
   import mips_pkg::*;

   logic        clock;
   logic        reset;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
   logic [1:0]  PCSource, ALUOp, ALUSrcB;
   logic [3:0]  state;
   logic        illegal_op;
   logic [31:0] instr_count;

   int errors = 0;
   int checks = 0;

   multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
      .clock       (clock),
      .reset       (reset),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp),
      .ALUSrcB     (ALUSrcB),
      .state       (state),
      .illegal_op  (illegal_op),
      .instr_count (instr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // All control outputs packed together for all-zero checks
   logic [15:0] all_ctrl;
   assign all_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   int cycles;
   int mw_cycles;
   int waits;
   int illegal_cycles;

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      opcode    = OP_RTYPE;
      #3;
      check("reset_state", 32'(state), 32'd0);
      check("reset_ctrl", 32'(all_ctrl), 32'd0);
      check("reset_count", instr_count, 32'd0);
      check("reset_illegal", 32'(illegal_op), 32'd0);

      @(negedge clock);
      reset = 1'b0;
      #1;
      // FETCH stalled on memory
      check("fetch_state", 32'(state), 32'd0);
      check("fetch_memread", 32'(MemRead), 32'd1);
      check("fetch_srcb", 32'(ALUSrcB), 32'd1);
      check("fetch_irwrite_stall", 32'(IRWrite), 32'd0);
      check("fetch_pcwrite_stall", 32'(PCWrite), 32'd0);
      tick();
      check("fetch_hold", 32'(state), 32'd0);
      mem_ready = 1'b1;
      #1;
      check("fetch_irwrite", 32'(IRWrite), 32'd1);
      check("fetch_pcwrite", 32'(PCWrite), 32'd1);

      // lw with no wait: 0,1,2,3,4,0
      opcode = OP_LW;
      tick();
      check("lw_decode", 32'(state), 32'd1);
      check("lw_decode_srcb", 32'(ALUSrcB), 32'd3);
      tick();
      check("lw_memaddr", 32'(state), 32'd2);
      check("lw_memaddr_ctl", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b1_10_00);
      tick();
      check("lw_memread", 32'(state), 32'd3);
      check("lw_memread_ctl", 32'({MemRead, IorD, MemWrite}), 32'b110);
      tick();
      check("lw_memwb", 32'(state), 32'd4);
      check("lw_memwb_ctl", 32'({RegWrite, MemtoReg, RegDst}), 32'b110);
      check("lw_count_before", instr_count, 32'd0);
      tick();
      check("lw_back_fetch", 32'(state), 32'd0);
      check("lw_count", instr_count, 32'd1);

      // sw with three wait cycles in MEM_WRITE
      opcode    = OP_SW;
      cycles    = 0;
      mw_cycles = 0;
      waits     = 0;
      do begin
         if (state == 4'd5 && waits < 3) begin
            mem_ready = 1'b0;
            waits++;
         end else begin
            mem_ready = 1'b1;
         end
         #1;
         if (MemWrite) mw_cycles++;
         cycles++;
         tick();
      end while (state != 4'd0 && cycles < 20);
      check("sw_cycles", 32'(cycles), 32'd7);
      check("sw_memwrite_cycles", 32'(mw_cycles), 32'd4);
      check("sw_count", instr_count, 32'd2);

      // beq then j, 6 cycles, +2 retired
      mem_ready = 1'b1;
      opcode    = OP_BEQ;
      tick();
      tick();
      check("beq_state", 32'(state), 32'd8);
      check("beq_ctl", 32'({PCWriteCond, PCSource, ALUOp, ALUSrcA, PCWrite}), 32'b1_01_01_1_0);
      tick();
      check("beq_back_fetch", 32'(state), 32'd0);
      opcode = OP_J;
      tick();
      tick();
      check("j_state", 32'(state), 32'd9);
      check("j_ctl", 32'({PCWrite, PCSource, PCWriteCond}), 32'b1_10_0);
      tick();
      check("bj_fetch", 32'(state), 32'd0);
      check("bj_count", instr_count, 32'd4);

      // Illegal opcode: DECODE then FETCH, one-cycle pulse, no retire
      opcode         = 6'b111111;
      illegal_cycles = 0;
      tick();
      check("ill_decode", 32'(state), 32'd1);
      if (illegal_op) illegal_cycles++;
      tick();
      check("ill_fetch", 32'(state), 32'd0);
      if (illegal_op) illegal_cycles++;
      mem_ready = 1'b0;
      tick();
      if (illegal_op) illegal_cycles++;
      check("ill_pulse_len", 32'(illegal_cycles), 32'd1);
      check("ill_count", instr_count, 32'd4);

      // addi: 0,1,10,11,0
      mem_ready = 1'b1;
      opcode    = OP_ADDI;
      tick();
      tick();
      check("addi_ex", 32'(state), 32'd10);
      check("addi_ex_ctl", 32'({ALUSrcA, ALUSrcB}), 32'b1_10);
      tick();
      check("addi_wb", 32'(state), 32'd11);
      check("addi_wb_ctl", 32'({RegWrite, RegDst, MemtoReg}), 32'b100);
      tick();
      check("addi_count", instr_count, 32'd5);

      // Counter wrap: preload all-ones, then retire an R-type
      mem_ready = 1'b0;
      force dut.u_retire.count = 32'hFFFF_FFFF;
      tick();
      release dut.u_retire.count;
      #1;
      check("wrap_preload", instr_count, 32'hFFFF_FFFF);
      mem_ready = 1'b1;
      opcode    = OP_RTYPE;
      tick();
      tick();
      check("r_execute", 32'(state), 32'd6);
      check("r_execute_ctl", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b1_00_10);
      tick();
      check("r_wb", 32'(state), 32'd7);
      check("r_wb_ctl", 32'({RegWrite, RegDst, MemtoReg}), 32'b110);
      tick();
      check("wrap_count", instr_count, 32'h0000_0000);

      // Reset while MEM_WRITE is stalled
      opcode = OP_SW;
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      check("rst_pre_state", 32'(state), 32'd5);
      check("rst_pre_memwrite", 32'(MemWrite), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_state", 32'(state), 32'd0);
      check("rst_async_ctrl", 32'(all_ctrl), 32'd0);
      check("rst_async_count", instr_count, 32'd0);
      tick();
      check("rst_hold_ctrl", 32'(all_ctrl), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_rel_state", 32'(state), 32'd0);
      check("rst_rel_memwrite", 32'(MemWrite), 32'd0);
      check("rst_rel_memread", 32'(MemRead), 32'd1);
      tick();
      check("rst_no_reissue", 32'({state, MemWrite}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
